// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and CPU clock stall
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        clk_stall,
    output logic        tx,
    output logic        irq_empty
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [1:0]        rst_sync_q;
    logic              rst_int_n;
    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              tx_q, tx_d, irq_q, irq_d;
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic              sel, wr_txdata, push, pop;
    logic [31:0]       count_ext;
    logic [3:0]        count_sat;
    logic              unused_sig;

    assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
    assign wr_txdata = sel & memwrite & ~addr[2];
    assign push      = wr_txdata & ~full_q;
    assign clk_stall = wr_txdata & full_q;
    assign tx        = tx_q;
    assign irq_empty = irq_q;
    assign rst_int_n = rst_sync_q[1];
    assign unused_sig = ^{sign_mask, write_data[31:8], addr[1:0]};

    // Reset synchroniser: asserts immediately, releases two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // STATUS register readback; count field saturates so deeper FIFOs still fit 4 bits
    always_comb begin
        count_ext = 32'(count_q);
        count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
        read_data = 32'h0;
        if (sel && memread && addr[2])
            read_data = {24'h0, count_sat, 1'b0, empty_q, full_q, (state_q != S_IDLE)};
    end

    // Serialiser FSM and FIFO bookkeeping; the STOP bit chains straight into the next START
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = fifo_q[rd_ptr_q];
                    baud_d  = BAUD_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                if (baud_q == '0) begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = fifo_q[rd_ptr_q];
                        baud_d  = BAUD_LOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        full_d   = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        irq_d    = empty_d & (state_d == S_IDLE);

        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= write_data[7:0];
    end

    // Registered state, all cleared by the synchronised reset
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            tx_q     <= 1'b1;
            irq_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            tx_q     <= tx_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - randomized self-checking bench for uart_tx_mmio with a frame-decoding reference
module tb_uart_tx_mmio;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [3:0]  sign_mask = 4'h0;
    logic [31:0] read_data;
    logic        clk_stall;
    logic        tx;
    logic        irq_empty;

    int tests_run = 0;
    int tests_failed = 0;
    int stall_viol = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         rx_ok_q[$];
    int         rx_start_q[$];

    uart_tx_mmio #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
        .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
        .read_data(read_data), .clk_stall(clk_stall), .tx(tx), .irq_empty(irq_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // clk_stall may only be raised while a TXDATA store is on the bus
    always @(negedge clk) begin
        #1;
        if (clk_stall && !(memwrite && addr[31:3] == BASE[31:3] && !addr[2]))
            stall_viol++;
    end

    // Line receiver: samples every clock, decodes 8N1 frames of 10*CPB cycles
    initial begin
        logic [39:0] s;
        logic [7:0]  b;
        bit          ok, aborted;
        int          st;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                st = cyc; aborted = 0; s = '0; s[0] = tx;
                for (int k = 1; k < 40; k++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1;
                    s[k] = tx;
                end
                if (!aborted) begin
                    ok = (s[3:0] == 4'h0) && (s[39:36] == 4'hF);
                    for (int i = 0; i < 8; i++) begin
                        b[i] = s[4 + 4*i];
                        if (s[4 + 4*i +: 4] != {4{s[4 + 4*i]}}) ok = 0;
                    end
                    rx_q.push_back(b);
                    rx_ok_q.push_back(ok);
                    rx_start_q.push_back(st);
                end
            end
        end
    end

    task automatic clear_queues();
        exp_q.delete(); rx_q.delete(); rx_ok_q.delete(); rx_start_q.delete();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d, output int stalls, output int pcyc);
        stalls = 0;
        @(negedge clk);
        addr = a; write_data = {24'($urandom), d}; memwrite = 1'b1; sign_mask = 4'($urandom);
        #1;
        while (clk_stall && stalls < 300) begin
            @(negedge clk); #1; stalls++;
        end
        if (stalls >= 300) begin
            tests_run++; tests_failed++;
            $display("FAIL write_stall_timeout: stalled %0d cycles, required < 300", stalls);
        end
        @(posedge clk); #1;
        pcyc = cyc;
        if (a[31:3] == BASE[31:3] && !a[2]) exp_q.push_back(d);
        memwrite = 1'b0; addr = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; memread = 1'b1;
        #1 d = read_data;
        memread = 1'b0; addr = 32'h0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (rx_q.size() < exp_q.size() && n < 5000) begin
            @(negedge clk); n++;
        end
        tests_run++;
        if (n >= 5000) begin
            tests_failed++;
            $display("FAIL drain_timeout: received %0d frames, required %0d", rx_q.size(), exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int bad = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tx, irq_empty, clk_stall, read_data} !== {3'b110, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: tx/irq/stall/rd=%b%b%b/%h required 110/00000000", tx, irq_empty, clk_stall, read_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || irq_empty !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL idle_lines: %0d cycles with tx or irq_empty low, required 0", bad);
        end
        bus_read(BASE + 32'd4, d);
        tests_run++;
        if (d !== 32'h4) begin
            tests_failed++;
            $display("FAIL reset_status: got %h required 00000004", d);
        end
    endtask

    task automatic test_single_frame();
        int st, pc;
        clear_queues();
        bus_write(BASE, 8'hA5, st, pc);
        tests_run++;
        if (irq_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_after_push: got %b required 0", irq_empty);
        end
        wait_drain();
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || !rx_ok_q[0]) begin
            tests_failed++;
            $display("FAIL single_frame: got %0d frames first %h ok %0d, required 1 frame a5 ok 1",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h0, (rx_ok_q.size() > 0) ? rx_ok_q[0] : 1'b0);
        end
        tests_run++;
        if (rx_start_q.size() < 1 || rx_start_q[0] - pc != 2) begin
            tests_failed++;
            $display("FAIL start_latency: got %0d required 2", (rx_start_q.size() > 0) ? rx_start_q[0] - pc : -1);
        end
        tests_run++;
        if (irq_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_after_frame: got %b required 1", irq_empty);
        end
    endtask

    task automatic test_back_to_back();
        int st, p1, pc, errs;
        logic [31:0] d;
        clear_queues();
        bus_write(BASE, 8'h01, st, p1);
        bus_write(BASE, 8'h02, st, pc);
        bus_write(BASE, 8'h03, st, pc);
        while (cyc < p1 + 10) @(negedge clk);
        bus_read(BASE + 32'd4, d);
        tests_run++;
        if (d !== 32'h21) begin
            tests_failed++;
            $display("FAIL b2b_status: got %h required 00000021", d);
        end
        wait_drain();
        errs = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i] || !rx_ok_q[i]) errs++;
        tests_run++;
        if (errs != 0 || rx_q.size() != 3) begin
            tests_failed++;
            $display("FAIL b2b_bytes: %0d bad of %0d received, required 0 bad of 3", errs, rx_q.size());
        end
        tests_run++;
        if (rx_start_q.size() != 3 || rx_start_q[1] - rx_start_q[0] != 10*CPB || rx_start_q[2] - rx_start_q[1] != 10*CPB) begin
            tests_failed++;
            $display("FAIL b2b_spacing: %0d frame starts, gaps not all %0d", rx_start_q.size(), 10*CPB);
        end
    endtask

    task automatic test_stall();
        int st, p0, pc, errs;
        logic [31:0] d;
        clear_queues();
        stall_viol = 0;
        bus_write(BASE, 8'($urandom), st, p0);
        for (int i = 0; i < 8; i++) bus_write(BASE, 8'($urandom), st, pc);
        bus_read(BASE + 32'd4, d);
        tests_run++;
        if (d !== 32'h83) begin
            tests_failed++;
            $display("FAIL full_status: got %h required 00000083", d);
        end
        bus_write(BASE, 8'h5A, st, pc);
        tests_run++;
        if (st == 0 || pc != p0 + 10*CPB + 2) begin
            tests_failed++;
            $display("FAIL stalled_push: stalled %0d cycles, push at +%0d, required >0 and +%0d", st, pc - p0, 10*CPB + 2);
        end
        wait_drain();
        errs = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i] || !rx_ok_q[i]) errs++;
        tests_run++;
        if (errs != 0 || rx_q.size() != 10 || rx_q[rx_q.size()-1] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL stall_bytes: %0d bad of %0d received, required 0 bad of 10 ending 5a", errs, rx_q.size());
        end
        tests_run++;
        if (stall_viol != 0) begin
            tests_failed++;
            $display("FAIL stall_without_write: got %0d cycles required 0", stall_viol);
        end
    endtask

    task automatic test_reset_mid_frame();
        int st, pc, bad;
        logic [31:0] d;
        clear_queues();
        bus_write(BASE, 8'($urandom), st, pc);
        bus_write(BASE, 8'($urandom), st, pc);
        bus_write(BASE, 8'($urandom), st, pc);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset_tx: got %b required 1", tx);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(BASE + 32'd4, d);
        tests_run++;
        if (d !== 32'h4) begin
            tests_failed++;
            $display("FAIL post_reset_status: got %h required 00000004", d);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0 || rx_q.size() != 0 || irq_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_resume: tx low %0d cycles, %0d frames, irq %b, required 0, 0, 1", bad, rx_q.size(), irq_empty);
        end
    endtask

    task automatic test_decode();
        int st, pc;
        logic [31:0] d0, d1, d2;
        clear_queues();
        bus_write(BASE + 32'd4, 8'($urandom), st, pc);
        tests_run++;
        if (st != 0) begin
            tests_failed++;
            $display("FAIL status_write_stall: got %0d cycles required 0", st);
        end
        bus_write(BASE + 32'd8, 8'($urandom), st, pc);
        tests_run++;
        if (st != 0) begin
            tests_failed++;
            $display("FAIL outside_write_stall: got %0d cycles required 0", st);
        end
        bus_read(BASE, d0);
        bus_read(BASE + 32'd8, d1);
        bus_read(BASE + 32'd4, d2);
        tests_run++;
        if ({d0, d1, d2} !== {32'h0, 32'h0, 32'h4}) begin
            tests_failed++;
            $display("FAIL decode_reads: got %h %h %h required 00000000 00000000 00000004", d0, d1, d2);
        end
        repeat (60) @(negedge clk);
        tests_run++;
        if (rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL decode_no_frame: got %0d frames required 0", rx_q.size());
        end
    endtask

    task automatic test_random();
        int st, pc, errs;
        logic [31:0] a;
        clear_queues();
        stall_viol = 0;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 5))
                0:       a = BASE + 32'd4;
                1:       a = BASE + 32'd8 + 32'($urandom_range(0, 3) * 4);
                default: a = BASE + 32'($urandom_range(0, 3));
            endcase
            bus_write(a, 8'($urandom), st, pc);
            repeat ($urandom_range(0, 50)) @(negedge clk);
        end
        wait_drain();
        errs = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i] || !rx_ok_q[i]) errs++;
        tests_run++;
        if (errs != 0 || rx_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL random_stream: %0d bad, %0d received, required 0 bad, %0d received", errs, rx_q.size(), exp_q.size());
        end
        tests_run++;
        if (irq_empty !== 1'b1 || stall_viol != 0) begin
            tests_failed++;
            $display("FAIL random_end_state: irq %b stall_viol %0d, required 1 and 0", irq_empty, stall_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_decode();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the CPU data bus, in parallel with data_mem.
- Decodes its own address window from the same address, write-data, memwrite, memread and sign_mask signals.
- Buffers bytes in a small FIFO and serialises them 8N1 on a TX pin.
- Drives clk_stall, ORed into the processor clock gate, when the CPU writes while the FIFO is full.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200).
BASE_ADDR, 32'h0000_2000, word-aligned base of the 8-byte register window.
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock, same ungated clk that data_mem uses.
rst_n  input  1  asynchronous active-low reset.
addr  input  32  CPU data address.
write_data  input  32  CPU store data; only [7:0] is used.
memwrite  input  1  store strobe.
memread  input  1  load strobe.
sign_mask  input  4  access size mask; accepted, ignored.
read_data  output  32  load data; 0 when not selected.
clk_stall  output  1  request to hold the processor clock high.
tx  output  1  UART serial out, idle high.
irq_empty  output  1  high when FIFO empty and shifter idle.

Behaviour:
- Reset (async assert, sync deassert via internal 2-flop synchroniser on rst_n):
  - tx=1, clk_stall=0, read_data=0, irq_empty=1.
  - FIFO pointers and count = 0; FSM = IDLE; baud counter = 0.
  - Reset mid-frame aborts the frame and drops tx to 1 immediately.
- Decode: sel = (addr[31:3] == BASE_ADDR[31:3]).
  - addr[2]=0: TXDATA, write-only; reads return 0.
  - addr[2]=1: STATUS, read-only; writes ignored.
- STATUS read_data fields (combinational from registered state when sel & memread & addr[2]):
  - [0] busy: FSM != IDLE.
  - [1] full.
  - [2] empty.
  - [7:4] count, where count saturates at 15.
  - other bits 0.
- Enqueue: at a rising clk where sel & memwrite & !addr[2] & !full_q, write_data[7:0] is pushed. One push per clk edge.
- Stall:
  - clk_stall = sel & memwrite & !addr[2] & full_q. It is combinational; full_q is the registered full flag.
  - While stalled, the CPU holds the store. The push happens on the first edge after full_q falls.
  - No byte is lost or duplicated.
- Simultaneous push and pop: allowed when not full; count unchanged; pointers both advance and wrap modulo FIFO_DEPTH.
  - When full, a pop in cycle N clears full_q at N+1. The stalled push lands at N+1, which guarantees one stall cycle minimum.
- TX FSM (states IDLE, START, DATA, STOP):
  - IDLE: tx=1. If FIFO is non-empty, pop into a shift register and go to START; the counter loads CLKS_PER_BIT-1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; shift right and increment the index. After index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then go to START directly if the FIFO is non-empty (pop on the same edge, no idle gap), else go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT clk cycles.
- Latency: the first start-bit edge on tx occurs 2 clk after the push edge when idle (push edge, then IDLE pop edge).
- tx is driven from a flop and is glitch-free.
- irq_empty = empty_q & (state==IDLE), registered.

Test Plan:
- Reset, no bus activity for 1000 clk -> tx=1, irq_empty=1, STATUS read at BASE+4 returns 32'h0000_0004.
- CLKS_PER_BIT=4; write 8'hA5 to BASE -> tx low 2 clk after push for 4 clk, then bits 1,0,1,0,0,1,0,1 (4 clk each), stop high 4 clk. Total 40 clk; irq_empty returns to 1.
- Write 3 bytes 8'h01,8'h02,8'h03 back-to-back -> three contiguous frames with no idle cycles between stop and next start. A STATUS read mid-first-frame returns busy=1, count=2.
- Fill FIFO (8 writes) during an active frame, then write 8'h5A -> clk_stall=1 until the current frame's STOP pops. The push lands exactly 1 clk after full_q falls; 8'h5A is transmitted last; clk_stall is never high without a pending write.
- Assert rst_n=0 mid-DATA bit of a frame -> tx=1 in the same cycle (async), FIFO empty, STATUS=32'h4 after release; no partial frame resumes.
- Write to BASE+4 and to BASE+8 (out of window), read BASE -> no enqueue, read_data=0, clk_stall=0.
